// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for alu_secuencial.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOR  = 3'b000,
    OP_NAND = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_ADDC = 3'b100,
    OP_SUBB = 3'b101,
    OP_XOR  = 3'b110,
    OP_MUL  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the {V, C, Z, N, P} flag vector
  localparam int FLAG_V = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 0;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add multiplier: operands load on start, then one multiplier bit is
// consumed per cycle for M cycles. done pulses during the last iteration and
// product presents the value that iteration produces, so the caller can
// register the final result on the same edge the iteration completes.
module mul_shift_add #(
  parameter int M = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [M-1:0]     a,
  input  logic [M-1:0]     b,
  output logic             done,
  output logic [2*M-1:0]   product
);

  localparam int CW = $clog2(M);

  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [2*M-1:0] r_acc;
  logic [2*M-1:0] r_mcand;
  logic [M-1:0]   r_mplier;
  logic [2*M-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign done       = r_busy && (r_cnt == CW'(M - 1));
  assign product    = w_acc_next;

  // Operand load on start, otherwise one partial-product step per busy cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{M{1'b0}}, a};
      r_mplier <= b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == CW'(M - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// Registered ALU with valid/ready handshakes, carry chaining through cin,
// accumulator operand mode and a multi-cycle multiplier.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic [2:0]   OpCode,
  input  logic         use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] Result,
  output logic [4:0]   flags
);

  state_t         r_state;
  logic [M-1:0]   r_result;
  logic [M-1:0]   r_acc;
  logic [4:0]     r_flags;
  logic           r_cin;

  opcode_t        w_op;
  logic           w_accept;
  logic           w_is_mul;
  logic           w_mul_start;
  logic           w_mul_done;
  logic [2*M-1:0] w_product;
  logic [M-1:0]   w_opa;
  logic [M:0]     w_arith;
  logic           w_cin_use;
  logic           w_is_arith;
  logic [M-1:0]   w_alu_res;
  logic           w_alu_v;
  logic           w_alu_c;
  logic [M-1:0]   w_fin_res;
  logic           w_fin_v;
  logic           w_fin_c;
  logic           w_complete;
  logic [4:0]     w_flags_next;

  assign w_op        = opcode_t'(OpCode);
  assign in_ready    = !reset && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign out_valid   = (r_state == DONE);
  assign Result      = r_result;
  assign flags       = r_flags;
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (w_op == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  // In DONE, r_acc already holds the result being consumed this cycle
  assign w_opa       = use_acc ? r_acc : A;

  mul_shift_add #(.M(M)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (w_opa),
    .b       (B),
    .done    (w_mul_done),
    .product (w_product)
  );

  // Single-cycle datapath, arithmetic carried out at M+1 bits
  always_comb begin
    w_alu_res  = '0;
    w_alu_v    = 1'b0;
    w_alu_c    = 1'b0;
    w_cin_use  = 1'b0;
    w_arith    = '0;
    w_is_arith = 1'b0;
    case (w_op)
      OP_NOR:  w_alu_res = ~(w_opa | B);
      OP_NAND: w_alu_res = ~(w_opa & B);
      OP_XOR:  w_alu_res = w_opa ^ B;
      OP_ADD, OP_ADDC: begin
        w_is_arith = 1'b1;
        w_cin_use  = (w_op == OP_ADDC) && r_cin;
        w_arith    = {1'b0, w_opa} + {1'b0, B} + {{M{1'b0}}, w_cin_use};
        w_alu_res  = w_arith[M-1:0];
        w_alu_c    = w_arith[M];
        w_alu_v    = (w_opa[M-1] == B[M-1]) && (w_alu_res[M-1] != w_opa[M-1]);
      end
      OP_SUB, OP_SUBB: begin
        w_is_arith = 1'b1;
        w_cin_use  = (w_op == OP_SUBB) && r_cin;
        w_arith    = {1'b0, w_opa} - {1'b0, B} - {{M{1'b0}}, w_cin_use};
        w_alu_res  = w_arith[M-1:0];
        // Bit M goes high exactly when Opa < B + cin (borrow out)
        w_alu_c    = w_arith[M];
        w_alu_v    = (w_opa[M-1] != B[M-1]) && (w_alu_res[M-1] != w_opa[M-1]);
      end
      default: begin
        w_alu_res = '0;
      end
    endcase
  end

  // Pick the completing source: multiplier finishing in BUSY, or a single-cycle op on accept
  always_comb begin
    w_complete = ((r_state == BUSY) && w_mul_done) || (w_accept && !w_is_mul);
    if (r_state == BUSY) begin
      w_fin_res = w_product[M-1:0];
      w_fin_v   = |w_product[2*M-1:M];
      w_fin_c   = 1'b0;
    end else begin
      w_fin_res = w_alu_res;
      w_fin_v   = w_alu_v;
      w_fin_c   = w_alu_c;
    end
    w_flags_next         = '0;
    w_flags_next[FLAG_V] = w_fin_v;
    w_flags_next[FLAG_C] = w_fin_c;
    w_flags_next[FLAG_Z] = (w_fin_res == '0);
    w_flags_next[FLAG_N] = w_fin_res[M-1];
    w_flags_next[FLAG_P] = ^w_fin_res;
  end

  // Handshake FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= w_is_mul ? BUSY : DONE;
          end
        end
        BUSY: begin
          if (w_mul_done) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (w_accept) begin
              r_state <= w_is_mul ? BUSY : DONE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result, flags, accumulator and carry-in update only on a completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_flags  <= '0;
      r_acc    <= '0;
      r_cin    <= 1'b0;
    end else if (w_complete) begin
      r_result <= w_fin_res;
      r_flags  <= w_flags_next;
      r_acc    <= w_fin_res;
      if (w_accept && w_is_arith) begin
        r_cin <= w_fin_c;
      end
    end
  end

endmodule
